// File: rtl/mem_arbiter_pkg.sv
// Shared constants, FSM encoding and transfer record for the two-cache memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 2;

  // Length field holds byte count minus one.
  localparam logic [LEN_W-1:0] LEN_BYTE = 2'b00;
  localparam logic [LEN_W-1:0] LEN_HALF = 2'b01;
  localparam logic [LEN_W-1:0] LEN_WORD = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_LAST = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  typedef struct packed {
    logic              port;
    logic              wr;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] din;
  } xfer_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the requester granted last loses a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic ptr;  // requester favoured on a tie

  always_comb begin
    // NOTE: default assignment first so every path drives gnt and no latch is inferred.
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) ptr <= 1'b0;
    else if (take && (gnt != 2'b00)) ptr <= gnt[0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two cache memory ports onto one byte-wide synchronous RAM, serialising 1-4 byte accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_re,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_raddr,
  input  logic [ADDR_W-1:0] c0_waddr,
  input  logic [LEN_W-1:0]  c0_rlen,
  input  logic [LEN_W-1:0]  c0_wlen,
  input  logic [DATA_W-1:0] c0_din,
  output logic [DATA_W-1:0] c0_dout,
  output logic              c0_rack,
  output logic              c0_wack,
  input  logic              c1_re,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_raddr,
  input  logic [ADDR_W-1:0] c1_waddr,
  input  logic [LEN_W-1:0]  c1_rlen,
  input  logic [LEN_W-1:0]  c1_wlen,
  input  logic [DATA_W-1:0] c1_din,
  output logic [DATA_W-1:0] c1_dout,
  output logic              c1_rack,
  output logic              c1_wack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata
);

  logic [2:0]        state;
  logic [LEN_W-1:0]  k;
  logic [LEN_W-1:0]  prev_k;
  logic [1:0]        mask;
  logic [1:0]        req;
  logic [1:0]        gnt;
  xfer_t             xf;
  xfer_t             xf_d;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W-1:0] cur_addr;

  // A port just acked is masked for one cycle so its still-high request is not re-served.
  assign req[0] = (c0_re | c0_we) & ~mask[0];
  assign req[1] = (c1_re | c1_we) & ~mask[1];

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .take (state == ST_IDLE),
    .gnt  (gnt)
  );

  always_comb begin
    xf_d      = '0;
    xf_d.port = gnt[1];
    if (gnt[1]) begin
      xf_d.wr   = c1_we;
      xf_d.base = c1_we ? c1_waddr : c1_raddr;
      xf_d.len  = c1_we ? c1_wlen : c1_rlen;
      xf_d.din  = c1_din;
    end else begin
      xf_d.wr   = c0_we;
      xf_d.base = c0_we ? c0_waddr : c0_raddr;
      xf_d.len  = c0_we ? c0_wlen : c0_rlen;
      xf_d.din  = c0_din;
    end
  end

  assign cur_addr = xf.base + ADDR_W'(k);
  assign prev_k   = k - LEN_W'(1);

  always_comb begin
    rd_word = hold;
    rd_word[8*xf.len +: 8] = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      mask    <= 2'b00;
      c0_dout <= '0;
      c1_dout <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mask <= 2'b00;
          k    <= '0;
          if (gnt != 2'b00) state <= xf_d.wr ? ST_WR : ST_RD;
        end
        ST_RD: begin
          if (k == xf.len) state <= ST_RD_LAST;
          else             k     <= k + LEN_W'(1);
        end
        ST_RD_LAST: begin
          if (xf.port) c1_dout <= rd_word;
          else         c0_dout <= rd_word;
          state <= ST_ACK;
        end
        ST_WR: begin
          if (k == xf.len) state <= ST_ACK;
          else             k     <= k + LEN_W'(1);
        end
        ST_ACK: begin
          mask  <= xf.port ? 2'b10 : 2'b01;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: transfer record and holding register carry no reset; they are always loaded at grant before use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && gnt != 2'b00) begin
      xf   <= xf_d;
      hold <= '0;
    end else if (state == ST_RD && k != '0) begin
      hold[8*prev_k +: 8] <= ram_rdata;
    end
  end

  assign ram_re    = (state == ST_RD);
  assign ram_we    = (state == ST_WR);
  assign ram_addr  = (ram_re || ram_we) ? cur_addr : '0;
  assign ram_wdata = ram_we ? xf.din[8*k +: 8] : 8'h00;

  assign c0_rack = (state == ST_ACK) && !xf.port && !xf.wr;
  assign c0_wack = (state == ST_ACK) && !xf.port &&  xf.wr;
  assign c1_rack = (state == ST_ACK) &&  xf.port && !xf.wr;
  assign c1_wack = (state == ST_ACK) &&  xf.port &&  xf.wr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              c0_re = 1'b0, c0_we = 1'b0, c1_re = 1'b0, c1_we = 1'b0;
  logic [ADDR_W-1:0] c0_raddr = '0, c0_waddr = '0, c1_raddr = '0, c1_waddr = '0;
  logic [LEN_W-1:0]  c0_rlen = '0, c0_wlen = '0, c1_rlen = '0, c1_wlen = '0;
  logic [DATA_W-1:0] c0_din = '0, c1_din = '0;
  logic [DATA_W-1:0] c0_dout, c1_dout;
  logic              c0_rack, c0_wack, c1_rack, c1_wack;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we, ram_re;
  logic [7:0]        ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_re(c0_re), .c0_we(c0_we), .c0_raddr(c0_raddr), .c0_waddr(c0_waddr),
    .c0_rlen(c0_rlen), .c0_wlen(c0_wlen), .c0_din(c0_din), .c0_dout(c0_dout),
    .c0_rack(c0_rack), .c0_wack(c0_wack),
    .c1_re(c1_re), .c1_we(c1_we), .c1_raddr(c1_raddr), .c1_waddr(c1_waddr),
    .c1_rlen(c1_rlen), .c1_wlen(c1_wlen), .c1_din(c1_din), .c1_dout(c1_dout),
    .c1_rack(c1_rack), .c1_wack(c1_wack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  // RAM model: 4 KiB window on the low address bits, plus a bench preload port.
  logic [7:0]  mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr[11:0]] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr[11:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          e0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic req_rd(input logic p, input logic [31:0] a, input logic [1:0] l);
    if (p) begin c1_re = 1'b1; c1_raddr = a; c1_rlen = l; end
    else   begin c0_re = 1'b1; c0_raddr = a; c0_rlen = l; end
  endtask

  task automatic req_wr(input logic p, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    if (p) begin c1_we = 1'b1; c1_waddr = a; c1_wlen = l; c1_din = d; end
    else   begin c0_we = 1'b1; c0_waddr = a; c0_wlen = l; c0_din = d; end
  endtask

  task automatic expect_ack(input logic p, input logic wr, input logic [31:0] d, input int at);
    exp_t e;
    e.port = p; e.wr = wr; e.data = d; e.at = at;
    sb.push_back(e);
  endtask

  task automatic expect_addrs(input logic [31:0] a, input logic [1:0] l);
    for (int i = 0; i <= int'(l); i++) addr_q.push_back(a + 32'(i));
  endtask

  // One clock: check RAM-side activity and acks at the negedge, then drop acked requests.
  task automatic step();
    logic [1:0] rack, wack, drop_r, drop_w;
    exp_t e;
    drop_r = 2'b00; drop_w = 2'b00;
    @(negedge clk);
    check("re_we_exclusive", {31'b0, ram_re & ram_we}, 32'h0);
    if (ram_re) begin
      if (addr_q.size() > 0) check("ram_re_addr", ram_addr, addr_q.pop_front());
      else                   check("ram_re_unexpected", {31'b0, ram_re}, 32'h0);
    end
    rack = {c1_rack, c0_rack};
    wack = {c1_wack, c0_wack};
    for (int p = 0; p < 2; p++) begin
      if (rack[p] || wack[p]) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", {30'b0, rack[p], wack[p]}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("ack_port_kind", {30'b0, 1'(p), wack[p]}, {30'b0, e.port, e.wr});
          if (!e.wr) check("rd_data", p ? c1_dout : c0_dout, e.data);
          if (e.at >= 0) check("ack_latency", 32'(cyc), 32'(e.at));
        end
        drop_r[p] = rack[p];
        drop_w[p] = wack[p];
      end
    end
    @(posedge clk); #1;
    if (drop_r[0]) c0_re = 1'b0;
    if (drop_w[0]) c0_we = 1'b0;
    if (drop_r[1]) c1_re = 1'b0;
    if (drop_w[1]) c1_we = 1'b0;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((sb.size() > 0 || addr_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("pending_acks", 32'(sb.size()), 32'h0);
    check("pending_addrs", 32'(addr_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    preload(12'h100, 8'h11); preload(12'h101, 8'h22);
    preload(12'h102, 8'h33); preload(12'h103, 8'h44);
    preload(12'h202, 8'h99);
    preload(12'hFFE, 8'h6B); preload(12'hFFF, 8'h5A);
    preload(12'h000, 8'h7C); preload(12'h001, 8'h8D);
    for (int i = 0; i < 4; i++) preload(12'h300 + 12'(i), 8'hEE);

    @(negedge clk);
    check("rst_strobes", {26'b0, ram_re, ram_we, c0_rack, c0_wack, c1_rack, c1_wack}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", {24'b0, ram_wdata}, 32'h0);
    check("rst_c0_dout", c0_dout, 32'h0);
    check("rst_c1_dout", c1_dout, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word read on port 0.
    req_rd(1'b0, 32'h100, LEN_WORD); e0 = cyc;
    expect_ack(1'b0, 1'b0, 32'h4433_2211, e0 + 6);
    expect_addrs(32'h100, LEN_WORD);
    run(40);

    // Two-byte write on port 1; upper din bytes ignored.
    req_wr(1'b1, 32'h200, LEN_HALF, 32'hAABB_CCDD); e0 = cyc;
    expect_ack(1'b1, 1'b1, 32'h0, e0 + 3);
    run(40);
    check("wr_byte0", {24'b0, mem[12'h200]}, 32'hDD);
    check("wr_byte1", {24'b0, mem[12'h201]}, 32'hCC);
    check("wr_byte2_untouched", {24'b0, mem[12'h202]}, 32'h99);
    check("c0_dout_hold", c0_dout, 32'h4433_2211);

    // Fresh reset, then simultaneous reads: port 0 wins the first tie.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("rst2_c0_dout", c0_dout, 32'h0);
    req_rd(1'b0, 32'h100, LEN_WORD); req_rd(1'b1, 32'h102, LEN_HALF); e0 = cyc;
    expect_ack(1'b0, 1'b0, 32'h4433_2211, e0 + 6);
    expect_ack(1'b1, 1'b0, 32'h0000_4433, -1);
    expect_addrs(32'h100, LEN_WORD); expect_addrs(32'h102, LEN_HALF);
    run(60);

    // Port 0 served last, so port 1 wins the next tie.
    req_rd(1'b0, 32'h101, LEN_BYTE); e0 = cyc;
    expect_ack(1'b0, 1'b0, 32'h0000_0022, e0 + 3);
    expect_addrs(32'h101, LEN_BYTE);
    run(40);
    req_rd(1'b0, 32'h100, LEN_HALF); req_rd(1'b1, 32'h103, LEN_BYTE);
    expect_ack(1'b1, 1'b0, 32'h0000_0044, -1);
    expect_ack(1'b0, 1'b0, 32'h0000_2211, -1);
    expect_addrs(32'h103, LEN_BYTE); expect_addrs(32'h100, LEN_HALF);
    run(60);

    // Write beats read within a port; the read then sees the new bytes.
    req_wr(1'b1, 32'h208, LEN_HALF, 32'h0000_BEEF); req_rd(1'b1, 32'h208, LEN_HALF); e0 = cyc;
    expect_ack(1'b1, 1'b1, 32'h0, e0 + 3);
    expect_ack(1'b1, 1'b0, 32'h0000_BEEF, -1);
    expect_addrs(32'h208, LEN_HALF);
    run(60);

    // Top-of-address-space byte read and a wrapping word read.
    req_rd(1'b0, 32'hFFFF_FFFF, LEN_BYTE); e0 = cyc;
    expect_ack(1'b0, 1'b0, 32'h0000_005A, e0 + 3);
    expect_addrs(32'hFFFF_FFFF, LEN_BYTE);
    run(40);
    req_rd(1'b1, 32'hFFFF_FFFE, LEN_WORD); e0 = cyc;
    expect_ack(1'b1, 1'b0, 32'h8D7C_5A6B, e0 + 6);
    expect_addrs(32'hFFFF_FFFE, LEN_WORD);
    run(40);

    // Reset lands while the word write is mid-way: bytes 2-3 never written, no ack.
    req_wr(1'b0, 32'h300, LEN_WORD, 32'h4433_2211);
    step();
    step();
    rst = 1'b1;
    step();
    check("abort_ram_we", {31'b0, ram_we}, 32'h0);
    check("abort_ram_addr", ram_addr, 32'h0);
    check("abort_ram_wdata", {24'b0, ram_wdata}, 32'h0);
    c0_we = 1'b0;
    rst = 1'b0;
    repeat (4) step();
    check("abort_byte0", {24'b0, mem[12'h300]}, 32'h11);
    check("abort_byte1", {24'b0, mem[12'h301]}, 32'h22);
    check("abort_byte2", {24'b0, mem[12'h302]}, 32'hEE);
    check("abort_byte3", {24'b0, mem[12'h303]}, 32'hEE);
    check("abort_c1_dout", c1_dout, 32'h0);

    req_rd(1'b0, 32'h300, LEN_WORD); e0 = cyc;
    expect_ack(1'b0, 1'b0, 32'hEEEE_2211, e0 + 6);
    expect_addrs(32'h300, LEN_WORD);
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
